pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard stall; PC and pending state hold while high.
REQ-005 branch_taken  input  1  ID-stage conditional branch resolved taken.
REQ-006 branch_target  input  32  branch target from the ID branch adder (PC + BImm).
REQ-007 jump  input  1  ID-stage unconditional jump.
REQ-008 jump_target  input  32  jump target.
REQ-009 pc  output  32  current fetch address, registered.
REQ-010 pc_plus4  output  32  pc + 4, combinational, modulo 2^32.
REQ-011 flush_if  output  1  kill the IF/ID instruction at the coming edge, combinational.
REQ-012 misalign  output  1  one-cycle pulse: the applied target had bits [1:0] != 0.
REQ-013 redirect_cnt  output  16  count of applied redirects, saturating.

Function
REQ-014 Redirect request: req = jump | branch_taken; sel_target = jump_target when jump, else branch_target (jump has priority).
REQ-015 States: RUN, PEND.
REQ-016 RUN, req=0, stall=0: pc <= pc + 4 (wrap 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 RUN, stall=1, req=0: pc holds; state stays RUN.
REQ-018 RUN, req=1, stall=0: redirect applied this edge; pc <= {sel_target[31:2],2'b00}; state stays RUN.
REQ-019 RUN, req=1, stall=1: pend_target <= sel_target; pc holds; state -> PEND.
REQ-020 PEND, stall=1: pc and pend_target hold; req, branch_target and jump_target ignored.
REQ-021 PEND, stall=0: redirect applied from pend_target; pc <= {pend_target[31:2],2'b00}; state -> RUN; req that cycle ignored.
REQ-022 Applied redirect (REQ-018/021): flush_if=1 in the same cycle, subject to REQ-029; misalign is registered, pulsing high for the cycle after the applying edge when the applied target had [1:0] != 0.
REQ-023 redirect_cnt increments by 1 per applied redirect; holds at 16'hFFFF.
REQ-024 flush_if=0 in every cycle with no applied redirect, including stall cycles and the RUN->PEND capture cycle.
REQ-025 Redirect latency: new pc visible 1 cycle after the request is applied; no added bubbles beyond flush_if.

Reset
REQ-026 rst=1 asynchronously forces pc=RESET_PC, state=RUN, pend_target=0, redirect_cnt=0, misalign=0.
REQ-027 rst asserted in PEND discards the pending redirect; first fetch after release is RESET_PC.
REQ-028 flush_if is combinational and follows its inputs during reset; the first edge after release advances pc to RESET_PC+4 when stall=0 and req=0.

Configuration
REQ-029 Macro BRANCH_DELAY_SLOT_EN defined: flush_if is tied 0 (the instruction in IF is the delay slot and completes); all other behaviour unchanged.
REQ-030 BRANCH_DELAY_SLOT_EN undefined: flush_if=1 on every applied redirect per REQ-022.

Verification
REQ-031 Reset then 3 run cycles, no req, stall=0 -> pc sequence 0x0, 0x4, 0x8, 0xC; flush_if=0 throughout.
REQ-032 At pc=0x10, branch_taken=1, branch_target=0x40, stall=0 -> flush_if=1 that cycle (macro off), next pc=0x40, redirect_cnt=1.
REQ-033 branch_taken=1, target=0x80, stall=1 for 3 cycles, then stall=0 with branch_taken=1, target=0x200 -> pc holds 3 cycles, then pc=0x80, 0x200 ignored, flush_if only on the release cycle.
REQ-034 jump=1, jump_target=0x100 together with branch_taken=1, branch_target=0x300 -> pc=0x100.
REQ-035 branch_target=0x42 applied -> pc=0x40, misalign high for exactly 1 cycle; pc=0xFFFF_FFFC, no req -> next pc=0x0; rst in PEND -> pc=RESET_PC, no later redirect.
REQ-036 Build with BRANCH_DELAY_SLOT_EN, rerun REQ-032 -> pc=0x40 and redirect_cnt=1 unchanged; flush_if stays 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, ID-stage branch/jump redirects, stall-deferred redirects.
// Optional build macro BRANCH_DELAY_SLOT_EN: the IF instruction after a redirect is a delay slot (no flush).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_if,
    output logic        misalign,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pend_target_r;
    logic [31:0] pend_next_s;
    logic [15:0] redirect_cnt_r;
    logic        misalign_r;
    logic        req_s;
    logic [31:0] sel_target_s;
    logic        apply_s;
    logic [31:0] applied_target_s;
    logic [31:0] pc_inc_s;

    // Redirect request decode; jump wins over a taken branch.
    always_comb begin
        req_s        = jump | branch_taken;
        sel_target_s = branch_target;
        if (jump) begin
            sel_target_s = jump_target;
        end else begin
            sel_target_s = branch_target;
        end
    end

    assign pc_inc_s = pc_r + 32'd4;

    // Next-state, next-PC and redirect-apply decision.
    always_comb begin
        state_next_s     = state_r;
        pc_next_s        = pc_r;
        pend_next_s      = pend_target_r;
        apply_s          = 1'b0;
        applied_target_s = 32'h0000_0000;
        case (state_r)
            ST_RUN: begin
                if (stall) begin
                    if (req_s) begin
                        // Redirect arrived during a stall: park it until the stall clears.
                        pend_next_s  = sel_target_s;
                        state_next_s = ST_PEND;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (req_s) begin
                    apply_s          = 1'b1;
                    applied_target_s = sel_target_s;
                    pc_next_s        = {sel_target_s[31:2], 2'b00};
                end else begin
                    pc_next_s = pc_inc_s;
                end
            end
            ST_PEND: begin
                if (stall) begin
                    state_next_s = ST_PEND;
                end else begin
                    // New requests this cycle are dropped: the parked one is older.
                    apply_s          = 1'b1;
                    applied_target_s = pend_target_r;
                    pc_next_s        = {pend_target_r[31:2], 2'b00};
                    state_next_s     = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
                pc_next_s    = pc_r;
            end
        endcase
    end

    // State, PC and pending-target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            pend_target_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            pend_target_r <= pend_next_s;
        end
    end

    // Saturating redirect counter and one-cycle misalignment flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_r <= 16'h0000;
            misalign_r     <= 1'b0;
        end else begin
            if (apply_s && (redirect_cnt_r != 16'hFFFF)) begin
                redirect_cnt_r <= redirect_cnt_r + 16'd1;
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
            misalign_r <= apply_s & (applied_target_s[1:0] != 2'b00);
        end
    end

    assign pc           = pc_r;
    assign pc_plus4     = pc_inc_s;
    assign misalign     = misalign_r;
    assign redirect_cnt = redirect_cnt_r;

`ifdef BRANCH_DELAY_SLOT_EN
    assign flush_if = 1'b0;
`else
    assign flush_if = apply_s;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (flush expectation follows BRANCH_DELAY_SLOT_EN).
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush_if;
    logic        misalign;
    logic [15:0] redirect_cnt;

    int checks;
    int errors;

`ifdef BRANCH_DELAY_SLOT_EN
    logic exp_flush = 1'b0;
`else
    logic exp_flush = 1'b1;
`endif

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush_if      (flush_if),
        .misalign      (misalign),
        .redirect_cnt  (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 actual=%h required=%h", pc_plus4, 32'h4); end
        checks++; if (redirect_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt actual=%h required=%h", redirect_cnt, 16'h0); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign actual=%b required=0", misalign); end
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL reset_flush actual=%b required=0", flush_if); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_run_sequence();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL run_pc[%0d] actual=%h required=%h", i, pc, exp_pc[i]); end
            checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL run_flush[%0d] actual=%b required=0", i, flush_if); end
        end
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL run_pc_10 actual=%h required=%h", pc, 32'h10); end
    endtask

    task automatic test_branch();
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        #1;
        checks++; if (flush_if !== exp_flush) begin errors++; $display("FAIL branch_flush actual=%b required=%b", flush_if, exp_flush); end
        tick();
        idle_inputs();
        #1;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_pc actual=%h required=%h", pc, 32'h40); end
        checks++; if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL branch_cnt actual=%0d required=1", redirect_cnt); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL branch_misalign actual=%b required=0", misalign); end
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL branch_flush_after actual=%b required=0", flush_if); end
    endtask

    task automatic test_stall_pend();
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        stall         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL stall_flush[%0d] actual=%b required=0", i, flush_if); end
            tick();
            checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_pc_hold[%0d] actual=%h required=%h", i, pc, 32'h40); end
            branch_target = 32'h999 + 32'(i);
            jump          = 1'b1;
            jump_target   = 32'h777;
        end
        stall         = 1'b0;
        jump          = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        #1;
        checks++; if (flush_if !== exp_flush) begin errors++; $display("FAIL release_flush actual=%b required=%b", flush_if, exp_flush); end
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL release_pc actual=%h required=%h", pc, 32'h80); end
        checks++; if (redirect_cnt !== 16'd2) begin errors++; $display("FAIL release_cnt actual=%0d required=2", redirect_cnt); end
        #1;
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL release_flush_after actual=%b required=0", flush_if); end
        tick();
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL ignored_req_pc actual=%h required=%h", pc, 32'h84); end
        checks++; if (redirect_cnt !== 16'd2) begin errors++; $display("FAIL ignored_req_cnt actual=%0d required=2", redirect_cnt); end
    endtask

    task automatic test_priority();
        jump          = 1'b1;
        jump_target   = 32'h100;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL priority_pc actual=%h required=%h", pc, 32'h100); end
        checks++; if (redirect_cnt !== 16'd3) begin errors++; $display("FAIL priority_cnt actual=%0d required=3", redirect_cnt); end
    endtask

    task automatic test_misalign();
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL misalign_pc actual=%h required=%h", pc, 32'h40); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse actual=%b required=1", misalign); end
        checks++; if (redirect_cnt !== 16'd4) begin errors++; $display("FAIL misalign_cnt actual=%0d required=4", redirect_cnt); end
        tick();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear actual=%b required=0", misalign); end
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL misalign_next_pc actual=%h required=%h", pc, 32'h44); end
    endtask

    task automatic test_wrap();
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_top actual=%h required=%h", pc, 32'hFFFF_FFFC); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 actual=%h required=%h", pc_plus4, 32'h0); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc actual=%h required=%h", pc, 32'h0); end
        checks++; if (redirect_cnt !== 16'd5) begin errors++; $display("FAIL wrap_cnt actual=%0d required=5", redirect_cnt); end
    endtask

    task automatic test_reset_in_pend();
        tick();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h500;
        stall         = 1'b1;
        tick();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL pend_entry_pc actual=%h required=%h", pc, 32'h8); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc actual=%h required=%h", pc, 32'h0); end
        checks++; if (redirect_cnt !== 16'h0) begin errors++; $display("FAIL async_reset_cnt actual=%0d required=0", redirect_cnt); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL post_reset_flush actual=%b required=0", flush_if); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_reset_pc actual=%h required=%h", pc, 32'h4); end
        tick();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL post_reset_pc2 actual=%h required=%h", pc, 32'h8); end
        checks++; if (redirect_cnt !== 16'h0) begin errors++; $display("FAIL post_reset_cnt actual=%0d required=0", redirect_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run_sequence();
        test_branch();
        test_stall_pend();
        test_priority();
        test_misalign();
        test_wrap();
        test_reset_in_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
